dac_spi_tx: RTL

DAC_SPI_TX -- requirements
Module: dac_spi_tx

---
 rtl/dac_spi_pkg.sv | 31 +++
 rtl/dac_sclk_gen.sv | 55 +++++
 rtl/dac_spi_tx.sv | 127 ++++++++++++
 3 files changed

// File: rtl/dac_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dac_spi_pkg
// Purpose  : Shared types, frame geometry and frame builder for the DAC SPI TX.
// Revision : 1.0 - initial release
// ============================================================================
package dac_spi_pkg;

    localparam int FRAME_W   = 16;
    localparam int CMD_W     = 4;
    localparam int PAD_W     = 4;
    localparam int SAMPLE_W  = FRAME_W - CMD_W - PAD_W;
    localparam int BIT_CNT_W = 4;
    localparam int DIV_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    function automatic logic [FRAME_W-1:0] build_frame(
        input logic [CMD_W-1:0]    cmd,
        input logic [SAMPLE_W-1:0] sample
    );
        return {cmd, sample, {PAD_W{1'b0}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/dac_sclk_gen.sv
`default_nettype none
// ============================================================================
// Module   : dac_sclk_gen
// Purpose  : Half-period counter, SCLK register and rise/fall strobes.
// Revision : 1.0 - initial release
// ============================================================================
module dac_sclk_gen
    import dac_spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clear,
    input  logic i_shift_en,
    output logic o_half_end,
    output logic o_rise,
    output logic o_fall,
    output logic o_sclk
);

    localparam logic [DIV_W-1:0] c_last_cnt = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_cnt;
    logic             r_sclk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!i_en || i_clear || o_half_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

    // SCLK is forced low whenever the FSM is not shifting, so it idles low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk <= 1'b0;
        end else if (!i_shift_en) begin
            r_sclk <= 1'b0;
        end else if (o_half_end) begin
            r_sclk <= ~r_sclk;
        end
    end

    assign o_half_end = i_en && (r_cnt == c_last_cnt);
    assign o_rise     = i_shift_en && o_half_end && !r_sclk;
    assign o_fall     = i_shift_en && o_half_end && r_sclk;
    assign o_sclk     = r_sclk;

endmodule
`default_nettype wire

// File: rtl/dac_spi_tx.sv
`default_nettype none
// ============================================================================
// Module   : dac_spi_tx
// Purpose  : Serialises 8-bit DDS samples into 16-bit SPI DAC frames.
// Revision : 1.0 - initial release
// ============================================================================
module dac_spi_tx
    import dac_spi_pkg::*;
#(
    parameter int               CLK_DIV = 4,
    parameter logic [CMD_W-1:0] CMD     = 4'b0011
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] din,
    input  logic                din_valid,
    output logic                din_ready,
    output logic                dac_cs_n,
    output logic                dac_sclk,
    output logic                dac_mosi,
    output logic                busy,
    output logic                frame_done
);

    localparam logic [BIT_CNT_W-1:0] c_last_bit = '1;

    state_t               r_state;
    state_t               w_next_state;
    logic [FRAME_W-1:0]   r_shift;
    logic [BIT_CNT_W-1:0] r_bit_cnt;
    logic                 r_ready_en;
    logic                 r_frame_done;

    logic w_accept;
    logic w_clear;
    logic w_busy;
    logic w_shifting;
    logic w_half_end;
    logic w_rise;
    logic w_fall;
    logic w_sclk;
    logic w_last_bit;
    logic w_unused_rise;

    assign w_busy        = (r_state != ST_IDLE);
    assign w_shifting    = (r_state == ST_SHIFT);
    assign w_accept      = din_valid && din_ready;
    assign w_last_bit    = (r_bit_cnt == c_last_bit);
    assign w_clear       = (w_next_state != r_state);
    assign w_unused_rise = w_rise;

    dac_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk        (clk),
        .rst        (rst),
        .i_en       (w_busy),
        .i_clear    (w_clear),
        .i_shift_en (w_shifting),
        .o_half_end (w_half_end),
        .o_rise     (w_rise),
        .o_fall     (w_fall),
        .o_sclk     (w_sclk)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept)                 w_next_state = ST_LOAD;
            ST_LOAD:  if (w_half_end)               w_next_state = ST_SHIFT;
            ST_SHIFT: if (w_fall && w_last_bit)     w_next_state = ST_HOLD;
            ST_HOLD:  if (w_half_end)               w_next_state = ST_IDLE;
            default:                                w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        din_ready  = 1'b0;
        dac_cs_n   = 1'b1;
        dac_mosi   = 1'b0;
        dac_sclk   = w_sclk;
        busy       = w_busy;
        frame_done = r_frame_done;
        case (r_state)
            ST_IDLE: din_ready = r_ready_en;
            ST_LOAD, ST_SHIFT: begin
                dac_cs_n = 1'b0;
                dac_mosi = r_shift[FRAME_W-1];
            end
            default: ;
        endcase
    end

    // The 16th falling edge leaves the register alone; SHIFT exits on it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (w_accept) begin
            r_shift   <= build_frame(CMD, din);
            r_bit_cnt <= '0;
        end else if (w_fall && !w_last_bit) begin
            r_shift   <= {r_shift[FRAME_W-2:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ready_en   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_ready_en   <= 1'b1;
            r_frame_done <= (r_state == ST_HOLD) && (w_next_state == ST_IDLE);
        end
    end

endmodule
`default_nettype wire
